// File: rtl/board_mem_arbiter.sv
// Arbiter and select sequencer for the shared board memory port (init/vali/flip/vga).
// Latency: request to grant is 1 cycle. Grants are never preempted. A starved VGA reader is promoted.
module board_mem_arbiter #(
    parameter int VGA_MAX_WAIT = 32,
    parameter int WAIT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic req_init,
    input  logic req_vali,
    input  logic req_flip,
    input  logic req_vga,
    output logic gnt_init,
    output logic gnt_vali,
    output logic gnt_flip,
    output logic gnt_vga,
    output logic init_ctrl,
    output logic vali_ctrl,
    output logic flip_ctrl,
    output logic vga_ctrl,
    output logic busy,
    output logic vga_promoted
);

    typedef enum logic {IDLE, OWNED} state_t;

    // Vector bit order everywhere: [3]=init [2]=vali [1]=flip [0]=vga
    localparam logic [3:0] SEL_INIT = 4'b1000;
    localparam logic [3:0] SEL_VALI = 4'b0100;
    localparam logic [3:0] SEL_FLIP = 4'b0010;
    localparam logic [3:0] SEL_VGA  = 4'b0001;
    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(VGA_MAX_WAIT);

    state_t            state, state_next;
    logic [3:0]        req, gnt, gnt_next, ctrl, ctrl_next, winner;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rearb;

    assign req = {req_init, req_vali, req_flip, req_vga};

    always_comb begin
        winner = '0;
        if (req_init)                    winner = SEL_INIT;
        else if (vga_promoted && req_vga) winner = SEL_VGA;
        else if (req_flip)               winner = SEL_FLIP;
        else if (req_vali)               winner = SEL_VALI;
        else if (req_vga)                winner = SEL_VGA;
    end

    // Re-arbitrate only when idle or when the current owner has let go.
    assign rearb = (state == IDLE) || ((gnt & req) == 4'b0000);

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        ctrl_next  = ctrl;
        if (rearb) begin
            if (winner != 4'b0000) begin
                state_next = OWNED;
                gnt_next   = winner;
                ctrl_next  = winner;
            end else begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            ctrl  <= SEL_INIT;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            ctrl  <= ctrl_next;
            busy  <= (gnt_next != 4'b0000);
        end
    end

    // Wait counter sees the pre-edge grant; promotion lags the counter by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt     <= '0;
            vga_promoted <= 1'b0;
        end else begin
            if (!req_vga || gnt[0] || gnt_next[0])
                wait_cnt <= '0;
            else if (wait_cnt != {WAIT_W{1'b1}})
                wait_cnt <= wait_cnt + 1'b1;
            vga_promoted <= (wait_cnt >= MAX_WAIT);
        end
    end

    assign {gnt_init, gnt_vali, gnt_flip, gnt_vga}     = gnt;
    assign {init_ctrl, vali_ctrl, flip_ctrl, vga_ctrl} = ctrl;

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Sequencer and arbiter for the shared 128×2-bit board memory port. Four engines compete for the port: board initialisation, move validation, disc flipping and the VGA scanout reader. The block grants the port to one requester at a time and drives the one-hot select lines (`init_ctrl`, `vali_ctrl`, `flip_ctrl`, `vga_ctrl`) of the board memory mux. A starvation guard keeps the display reader from being locked out during long game-logic bursts.

## Interface
Parameters:
- `VGA_MAX_WAIT`, default 32: cycles `req_vga` may wait ungranted before VGA is promoted; legal range 1..2^`WAIT_W`-1.
- `WAIT_W`, default 6: width of the VGA wait counter.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_init`  in  1  initialiser requests the port; held high for the whole transaction.
- `req_vali`  in  1  validator request; same rule.
- `req_flip`  in  1  flipper request; same rule.
- `req_vga`  in  1  VGA reader request; same rule.
- `gnt_init`, `gnt_vali`, `gnt_flip`, `gnt_vga`  out  1 each  transaction grant; at most one high.
- `init_ctrl`, `vali_ctrl`, `flip_ctrl`, `vga_ctrl`  out  1 each  mux selects; exactly one high at all times.
- `busy`  out  1  high while any `gnt_*` is high.
- `vga_promoted`  out  1  high while the VGA wait counter is at or above `VGA_MAX_WAIT`.

## Operation
- Two states:
  - IDLE: no grant.
  - OWNED: one grant, which is the owner.
- Every output is a register; none is driven combinationally from a request.
- Normal priority: init > flip > vali > vga.
- Promoted priority: when `vga_promoted` is set, the order is init > vga > flip > vali.
- Arbitration happens in a cycle where either:
  - the state is IDLE, or
  - the state is OWNED and the owner's `req_*` is sampled low.
- The winner among the sampled-high requests gets `gnt_*` and `*_ctrl` from the next cycle.
- If no request is high, the state becomes IDLE and all `gnt_*` go low.
- OWNED with the owner's `req_*` still high: the grant is held and nothing is preempted, including by `req_init`.
- A requester that drops and re-raises its request must go through arbitration again.
- Selects park on the last grantee:
  - In IDLE, the `*_ctrl` of the most recent owner stays high, so the mux output never goes undefined.
  - After reset the parked select is `init_ctrl`.
- Client contract, not checked by the block: every client drives its `wren_*` low whenever its `req_*` is low. Parked selects then never write.
- VGA wait counter (`WAIT_W` bits):
  - Increments each cycle `req_vga` is high and `gnt_vga` is low.
  - Saturates at all-ones.
  - Clears to 0 in the cycle `gnt_vga` is set, and whenever `req_vga` is low.
  - `vga_promoted` = counter ≥ `VGA_MAX_WAIT`, registered.
- Simultaneous release and request: the owner's request low and other requests high in the same cycle gives a direct handover, with no idle cycle.
- Reset values:
  - `gnt_*` = 0, `busy` = 0, `vga_promoted` = 0.
  - `init_ctrl` = 1; `vali_ctrl`, `flip_ctrl`, `vga_ctrl` = 0.
  - Counter = 0; state = IDLE.
  - Reset asserted mid-transaction drops the grant on the next edge, regardless of requests.

## Timing
- Request to grant latency: `req_x` sampled high at edge N (IDLE, winner) → `gnt_x` and `x_ctrl` high after edge N, i.e. visible in cycle N+1.
- Release: owner `req` sampled low at edge M → `gnt` low in cycle M+1. In the same cycle M+1 the next winner's `gnt` and `ctrl` go high.
- A client must not drive its address and data until it sees its `gnt` high. Its first memory access is in the cycle `gnt` is first seen high.
- `busy` and the `ctrl` one-hot switch on the same edge as `gnt`.
- The counter uses the pre-edge `gnt_vga`. Promotion therefore takes effect one cycle after the counter reaches `VGA_MAX_WAIT`.
- Minimum gap between two grants to the same client: 2 cycles (request low for at least one sampled edge).

## Test plan
- Reset state: assert `reset` for 2 cycles with all requests high → `init_ctrl`=1, all `gnt_*`=0. After release, `gnt_init`=1 on the first edge.
- Priority: raise `req_vali`, `req_flip`, `req_vga` at the same edge from IDLE → `gnt_flip` the next cycle. Drop `req_flip` → `gnt_vali`; drop it → `gnt_vga`. Each handover takes exactly one cycle with `busy` staying 1.
- No preemption and parking: `gnt_vali` owner, then raise `req_init` → `gnt_vali` stays until `req_vali` drops, then `gnt_init`. Drop `req_init` with no other request → `busy`=0 and `init_ctrl` stays 1.
- Starvation guard (`VGA_MAX_WAIT`=4): flip and vali alternate continuously while `req_vga` is held → `vga_promoted`=1 after 4 waiting cycles. VGA wins the next arbitration over a pending `req_flip`, and the counter clears on `gnt_vga`.
- Mid-transaction reset: `gnt_flip` high, pulse `reset` for 1 cycle → all `gnt_*`=0, `init_ctrl`=1. With `req_flip` still high, `gnt_flip` returns one cycle after `reset` deasserts.
- One-hot invariant: 10k cycles of random requests, each held for a random duration → checker confirms exactly one `*_ctrl` high every cycle and at most one `gnt_*` high. `gnt_x` is never high while `req_x` was sampled low on the previous edge.
